router_reg: RTL and testbench

ROUTER_REG -- requirements
Module: router_reg

---
 rtl/router_reg.sv | 113 +++++++++++
 tb/tb_router_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/router_reg.sv
// Router datapath register stage: header/full-hold capture, output byte, packet-end and parity status.
// Define ROUTER_REG_PARITY_CHECK_EN to build the running-parity check that drives err.
module router_reg (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       rst_int_reg,
  output logic [7:0] dout,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic       err
);

  logic [7:0] hdr_q;
  logic [7:0] hold_q;
  logic       set_pd;
  logic       laf_par;

  // parity byte was parked in hold_q by a stalled ld cycle and is released here
  assign laf_par = laf_state && low_pkt_valid && !parity_done;
  assign set_pd  = !detect_add &&
                   ((ld_state && !fifo_full && !pkt_valid) || laf_par);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      hdr_q <= 8'h00;
    else if (detect_add && pkt_valid && data_in[1:0] != 2'b11)
      hdr_q <= data_in;
  end

  // detect_add masks every other strobe's effect on the datapath
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout   <= 8'h00;
      hold_q <= 8'h00;
    end else if (!detect_add) begin
      if (lfd_state)
        dout <= hdr_q;
      else if (ld_state) begin
        if (!fifo_full) dout   <= data_in;
        else            hold_q <= data_in;
      end else if (laf_state)
        dout <= hold_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      low_pkt_valid <= 1'b0;
    else if (!detect_add) begin
      if (rst_int_reg)
        low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid)
        low_pkt_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      parity_done <= 1'b0;
    else if (detect_add)
      parity_done <= 1'b0;
    else if (set_pd)
      parity_done <= 1'b1;
  end

`ifdef ROUTER_REG_PARITY_CHECK_EN
  logic [7:0] run_par;
  logic [7:0] pkt_par;
  logic       pd_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run_par <= 8'h00;
      pkt_par <= 8'h00;
      pd_q    <= 1'b0;
      err     <= 1'b0;
    end else begin
      pd_q <= parity_done;
      if (detect_add) begin
        run_par <= 8'h00;
        err     <= 1'b0;
      end else begin
        if (lfd_state)
          run_par <= run_par ^ hdr_q;
        else if (ld_state && pkt_valid && !full_state)
          run_par <= run_par ^ data_in;

        if (ld_state && !pkt_valid && !fifo_full)
          pkt_par <= data_in;
        else if (laf_par)
          pkt_par <= hold_q;

        // compare once, the cycle after parity_done rises, so pkt_par is settled
        if (parity_done && !pd_q)
          err <= (run_par != pkt_par);
      end
    end
  end
`else
  logic unused_full_state;
  assign unused_full_state = full_state;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: the bench plays router_fsm and checks against packet-level expectations.
module tb_router_reg;

  localparam bit ERR_EN =
`ifdef ROUTER_REG_PARITY_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;

  int ntests = 0;
  int nfail  = 0;

  // behavioural expectations: last forwarded byte, last accepted header
  logic [7:0] exp_dout = 8'h00;
  logic [7:0] last_hdr = 8'h00;
  logic [7:0] pay_q[$];

  router_reg dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0; fifo_full = 0; pkt_valid = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Full packet: header, payload from pay_q, parity byte. stall_mask bit i stalls payload byte i.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par,
                          input int unsigned stall_mask, input bit stall_par);
    logic [7:0] x;
    logic       exp_err;
    clr(); detect_add = 1; pkt_valid = 1; data_in = hdr; tick();
    if (hdr[1:0] != 2'b11) last_hdr = hdr;
    chk("det_dout_hold", dout, exp_dout);
    chk("det_pd_clr", {7'b0, parity_done}, 8'h00);
    chk("det_err_clr", {7'b0, err}, 8'h00);

    clr(); lfd_state = 1; pkt_valid = 1; data_in = pay_q[0]; tick();
    exp_dout = last_hdr;
    chk("lfd_dout", dout, exp_dout);

    x = last_hdr;
    for (int i = 0; i < pay_q.size(); i++) begin
      x ^= pay_q[i];
      clr(); ld_state = 1; pkt_valid = 1; data_in = pay_q[i];
      if (stall_mask[i % 32]) begin
        fifo_full = 1; tick();
        chk("ld_full_hold", dout, exp_dout);
        clr(); full_state = 1; fifo_full = 1; pkt_valid = 1; data_in = pay_q[i]; tick();
        chk("full_hold", dout, exp_dout);
        clr(); laf_state = 1; pkt_valid = 1; tick();
        exp_dout = pay_q[i];
        chk("laf_dout", dout, exp_dout);
      end else begin
        tick();
        exp_dout = pay_q[i];
        chk("ld_dout", dout, exp_dout);
      end
    end
    chk("pay_pd_low", {7'b0, parity_done}, 8'h00);
    chk("pay_lpv_low", {7'b0, low_pkt_valid}, 8'h00);

    clr(); ld_state = 1; pkt_valid = 0; data_in = par;
    if (stall_par) begin
      fifo_full = 1; tick();
      chk("parst_dout", dout, exp_dout);
      chk("parst_lpv", {7'b0, low_pkt_valid}, 8'h01);
      chk("parst_pd", {7'b0, parity_done}, 8'h00);
      clr(); full_state = 1; fifo_full = 1; tick();
      clr(); laf_state = 1; tick();
    end else begin
      tick();
    end
    exp_dout = par;
    chk("par_dout", dout, exp_dout);
    chk("par_pd", {7'b0, parity_done}, 8'h01);
    chk("par_lpv", {7'b0, low_pkt_valid}, 8'h01);
    chk("par_err_wait", {7'b0, err}, 8'h00);

    exp_err = ERR_EN && (x != par);
    clr(); tick();
    chk("err", {7'b0, err}, {7'b0, exp_err});

    clr(); rst_int_reg = 1; tick();
    chk("rstint_lpv", {7'b0, low_pkt_valid}, 8'h00);
    chk("rstint_pd", {7'b0, parity_done}, 8'h01);
    chk("rstint_err", {7'b0, err}, {7'b0, exp_err});
  endtask

  initial begin
    resetn = 0; data_in = 8'h00; clr();
    #1;
    chk("rst_dout", dout, 8'h00);
    chk("rst_pd", {7'b0, parity_done}, 8'h00);
    chk("rst_lpv", {7'b0, low_pkt_valid}, 8'h00);
    chk("rst_err", {7'b0, err}, 8'h00);
    // strobes while in reset have no effect
    ld_state = 1; data_in = 8'hAA; tick();
    chk("rst_ld_ignored", dout, 8'h00);
    clr(); resetn = 1; tick();

    // nominal packet, good then bad parity
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, 8'h0D, 0, 0);
    send_pkt(8'h0D, 8'hFF, 0, 0);
    // stall on 8'h22; parity must count it once
    send_pkt(8'h0D, 8'h0D, 32'b010, 0);

    // reserved destination: header register keeps 8'h0D
    clr(); detect_add = 1; pkt_valid = 1; data_in = 8'h03; tick();
    chk("det03_pd", {7'b0, parity_done}, 8'h00);
    clr(); lfd_state = 1; tick();
    exp_dout = last_hdr;
    chk("det03_lfd", dout, 8'h0D);

    // detect_add outranks simultaneous strobes
    clr(); detect_add = 1; lfd_state = 1; ld_state = 1; pkt_valid = 1; data_in = 8'h55; tick();
    last_hdr = 8'h55;
    chk("prio_dout", dout, exp_dout);
    clr(); lfd_state = 1; tick();
    exp_dout = last_hdr;
    chk("prio_lfd", dout, 8'h55);

    // rst_int_reg wins over a low_pkt_valid set
    clr(); ld_state = 1; fifo_full = 1; data_in = 8'h00; tick();
    chk("lpv_set", {7'b0, low_pkt_valid}, 8'h01);
    clr(); ld_state = 1; fifo_full = 1; rst_int_reg = 1; tick();
    chk("lpv_clr_wins", {7'b0, low_pkt_valid}, 8'h00);
    chk("lpv_dout_hold", dout, exp_dout);

    for (int p = 0; p < 30; p++) begin
      logic [7:0] h, x, par;
      int unsigned len;
      len = $urandom_range(1, 6);
      h = {6'(len), 2'($urandom_range(0, 2))};
      pay_q.delete();
      x = h;
      for (int i = 0; i < int'(len); i++) begin
        pay_q.push_back(8'($urandom));
        x ^= pay_q[i];
      end
      par = ($urandom_range(0, 1) == 1) ? x : (x ^ 8'($urandom_range(1, 255)));
      send_pkt(h, par, $urandom, 1'($urandom_range(0, 1)));
    end

    // reset mid-payload
    clr(); detect_add = 1; pkt_valid = 1; data_in = 8'h0D; tick();
    clr(); lfd_state = 1; pkt_valid = 1; tick();
    clr(); ld_state = 1; pkt_valid = 1; data_in = 8'h11; tick();
    chk("mid_dout", dout, 8'h11);
    #2 resetn = 0;
    #1;
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_pd", {7'b0, parity_done}, 8'h00);
    chk("mid_rst_lpv", {7'b0, low_pkt_valid}, 8'h00);
    chk("mid_rst_err", {7'b0, err}, 8'h00);
    tick();
    clr(); resetn = 1; tick();
    // header register was cleared by reset
    clr(); lfd_state = 1; tick();
    chk("post_rst_lfd", dout, 8'h00);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
